// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// Holds the op encodings, FSM state encodings, datapath width and the
// register-file indices of HI/LO targeted by the double write port.
package muldiv_unit_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int HI_IDX     = 33;
  localparam int LO_IDX     = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and muldiv_unit.
//   master: EX stage / pipeline control (drives start, op, operands, cancel)
//   slave : muldiv_unit (drives busy, done, result_wen, result)
// result is {HI,LO} and feeds the register file double_wdata port;
// result_wen feeds double_wen.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   src_a;
  logic [WIDTH-1:0]   src_b;
  logic               cancel;
  logic               busy;
  logic               done;
  logic               result_wen;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, op, src_a, src_b, cancel,
    input  busy, done, result_wen, result
  );

  modport slave (
    input  start, op, src_a, src_b, cancel,
    output busy, done, result_wen, result
  );
endinterface

// File: rtl/muldiv_unit_iter.sv
// muldiv_iter: one combinational iteration of the unsigned datapath.
//   acc      : partial accumulator, {hi, lo}
//   operand  : multiplicand (multiply) or divisor (divide)
//   is_div   : 1 selects restoring divide, 0 selects shift-add multiply
//   acc_next : accumulator after this iteration
// Multiply: acc = {partial product, remaining multiplier bits}; add the
// multiplicand into hi when lo[0] is set, then shift the whole thing right.
// Divide: acc = {remainder, remaining dividend / growing quotient}; shift
// left, trial-subtract the divisor, keep it if non-negative.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    diff     = rem_sh - {1'b0, operand};
    acc_next = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (diff[WIDTH])
        acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU for the EX stage.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : muldiv_unit_if slave (start/op/src_a/src_b/cancel in,
//          busy/done/result_wen/result out)
// Operands are made unsigned on accept, iterated WIDTH cycles in CALC,
// sign-corrected in FIX, and written out with a one-cycle strobe in DONE.
import muldiv_unit_pkg::*;

module muldiv_unit #(
  parameter int WIDTH = DATA_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_next;
  logic [WIDTH-1:0]   operand_q;
  logic               is_div_q, sign_q, sign_r, div_zero_q;
  logic [2*WIDTH-1:0] result_q, fixed;

  logic               op_signed, op_div;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .acc      (acc_q),
    .operand  (operand_q),
    .is_div   (is_div_q),
    .acc_next (acc_next)
  );

  always_comb begin
    op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    op_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    a_abs     = (op_signed && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
    b_abs     = (op_signed && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;
  end

  // Divide by zero: the unsigned core leaves remainder=|a|, and the sign_r
  // fix-up turns that back into src_a, so only the quotient is overridden.
  always_comb begin
    quot_fix = div_zero_q ? '1 : (sign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    rem_fix  = sign_r ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    fixed    = is_div_q ? {rem_fix, quot_fix} : (sign_q ? -acc_q : acc_q);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.start && !bus.cancel) state_d = S_CALC;
      S_CALC: begin
        if (bus.cancel)          state_d = S_IDLE;
        else if (cnt_q == LAST)  state_d = S_FIX;
      end
      S_FIX:  state_d = bus.cancel ? S_IDLE : S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      operand_q  <= '0;
      is_div_q   <= 1'b0;
      sign_q     <= 1'b0;
      sign_r     <= 1'b0;
      div_zero_q <= 1'b0;
      result_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (bus.start && !bus.cancel) begin
          cnt_q      <= '0;
          is_div_q   <= op_div;
          sign_q     <= op_signed && (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
          sign_r     <= op_signed && bus.src_a[WIDTH-1];
          div_zero_q <= (bus.src_b == '0);
          if (op_div) begin
            acc_q     <= {{WIDTH{1'b0}}, a_abs};
            operand_q <= b_abs;
          end else begin
            acc_q     <= {{WIDTH{1'b0}}, b_abs};
            operand_q <= a_abs;
          end
        end
        S_CALC: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        S_FIX: if (!bus.cancel) result_q <= fixed;
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.result_wen = (state_q == S_DONE);
  assign bus.result     = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Pulse start for one cycle (sampled at edge T), leaving the caller at the
  // negedge of cycle 1, then wait for done. cyc is the cycle done was seen
  // relative to start (34 expected), or 999 if it never came.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int cyc,
                       output logic [63:0] res);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.done) cyc = 999;
    res = bus.result;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.cancel = 1'b0; bus.op = 2'b00;
    bus.src_a = '0; bus.src_b = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.result_wen} !== 3'b000 || bus.result !== 64'h0) begin
      errors++;
      $display("FAIL reset: busy/done/wen=%b%b%b result=%h required 000 / 0",
               bus.busy, bus.done, bus.result_wen, bus.result);
    end
  endtask

  task automatic test_multu_latency();
    int n_done = 0, done_cyc = -1, busy_bad = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULTU; bus.src_a = 32'hFFFF_FFFF; bus.src_b = 32'hFFFF_FFFF;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL latency_busy0: busy=%b required 0", bus.busy);
    end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy !== (c <= 34)) busy_bad++;
      if (bus.done === 1'b1) begin n_done++; done_cyc = c; end
      if (bus.result_wen !== bus.done) busy_bad++;
      if (c == 34) begin
        checks++;
        if (bus.result !== 64'hFFFF_FFFE_0000_0001) begin
          errors++; $display("FAIL multu_max: result=%h required fffffffe00000001", bus.result);
        end
      end
    end
    checks++;
    if (n_done != 1 || done_cyc != 34) begin
      errors++; $display("FAIL latency_done: %0d pulses last at %0d required 1 at 34", n_done, done_cyc);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++; $display("FAIL latency_busy: %0d bad busy/wen cycles required 0", busy_bad);
    end
  endtask

  task automatic test_signed();
    int cyc; logic [63:0] res;
    logic [1:0]  ops  [4] = '{OP_MULT, OP_DIV, OP_DIVU, OP_MULT};
    logic [31:0] as   [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000};
    logic [31:0] bs   [4] = '{32'd3, 32'd2, 32'd7, 32'h8000_0000};
    logic [63:0] exps [4] = '{64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFD,
                              64'h0000_0002_0000_000E, 64'h4000_0000_0000_0000};
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], as[i], bs[i], cyc, res);
      checks++;
      if (res !== exps[i] || cyc != 34) begin
        errors++;
        $display("FAIL arith_%0d: result=%h at cycle %0d required %h at 34", i, res, cyc, exps[i]);
      end
    end
  endtask

  task automatic test_edges();
    int cyc; logic [63:0] res;
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, res);
    checks++;
    if (res !== 64'h0000_0000_8000_0000) begin
      errors++; $display("FAIL div_overflow: result=%h required 0000000080000000", res);
    end
    do_op(OP_DIVU, 32'd5, 32'd0, cyc, res);
    checks++;
    if (res !== 64'h0000_0005_FFFF_FFFF || cyc != 34) begin
      errors++; $display("FAIL divu_zero: result=%h at %0d required 00000005ffffffff at 34", res, cyc);
    end
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, cyc, res);
    checks++;
    if (res !== 64'hFFFF_FFF9_FFFF_FFFF) begin
      errors++; $display("FAIL div_zero_neg: result=%h required fffffff9ffffffff", res);
    end
    do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, cyc, res);
    checks++;
    if (res !== 64'h0000_0001_FFFF_FFFD) begin
      errors++; $display("FAIL div_neg_divisor: result=%h required 00000001fffffffd", res);
    end
  endtask

  task automatic test_ignore_start();
    int n_done = 0, done_cyc = -1;
    logic [63:0] res = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULTU; bus.src_a = 32'h1234_5678; bus.src_b = 32'h10;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.start = (c == 5 || c == 20);
      if (c == 5 || c == 20) begin bus.src_a = 32'd9; bus.src_b = 32'd9; end
      if (bus.done === 1'b1) begin n_done++; done_cyc = c; res = bus.result; end
    end
    bus.start = 1'b0;
    checks++;
    if (n_done != 1 || done_cyc != 34 || res !== 64'h0000_0001_2345_6780) begin
      errors++;
      $display("FAIL ignore_start: %0d done at %0d result=%h required 1 at 34 result 0000000123456780",
               n_done, done_cyc, res);
    end
  endtask

  task automatic test_cancel();
    int n_done = 0;
    logic [63:0] prev;
    prev = bus.result;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULTU; bus.src_a = 32'd3; bus.src_b = 32'd3;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.cancel = (c == 10);
      if (bus.done === 1'b1) n_done++;
      if (c == 11) begin
        checks++;
        if (bus.busy !== 1'b0) begin
          errors++; $display("FAIL cancel_busy: busy=%b at cycle 11 required 0", bus.busy);
        end
      end
    end
    bus.cancel = 1'b0;
    checks++;
    if (n_done != 0 || bus.result !== prev) begin
      errors++;
      $display("FAIL cancel_nodone: %0d done result=%h required 0 done result %h", n_done, bus.result, prev);
    end
    // start together with cancel in IDLE is dropped
    @(negedge clk);
    bus.start = 1'b1; bus.cancel = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL cancel_idle: busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int cyc1, cyc2; logic [63:0] r1, r2;
    do_op(OP_MULTU, 32'd3, 32'd5, cyc1, r1);
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULTU; bus.src_a = 32'h0001_0000; bus.src_b = 32'h0001_0000;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.result !== 64'd15) begin
      errors++; $display("FAIL b2b_accept: busy=%b result=%h required 1 / f", bus.busy, bus.result);
    end
    cyc2 = 1;
    while (!bus.done && cyc2 < 60) begin
      @(negedge clk);
      cyc2++;
      if (!bus.done && bus.result !== 64'd15) begin
        checks++; errors++;
        $display("FAIL b2b_hold: result=%h at %0d required f", bus.result, cyc2);
      end
    end
    r2 = bus.result;
    checks++;
    if (r1 !== 64'd15 || r2 !== 64'h0000_0001_0000_0000 || cyc1 != 34 || cyc2 != 34) begin
      errors++;
      $display("FAIL b2b: r1=%h@%0d r2=%h@%0d required f@34 0000000100000000@34", r1, cyc1, r2, cyc2);
    end
  endtask

  task automatic test_rst_abort();
    int cyc; logic [63:0] res;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIVU; bus.src_a = 32'd50; bus.src_b = 32'd5;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.result_wen} !== 3'b000 || bus.result !== 64'h0) begin
      errors++;
      $display("FAIL rst_abort: busy/done/wen=%b%b%b result=%h required 000 / 0",
               bus.busy, bus.done, bus.result_wen, bus.result);
    end
    do_op(OP_DIVU, 32'd50, 32'd5, cyc, res);
    checks++;
    if (res !== 64'h0000_0000_0000_000A || cyc != 34) begin
      errors++; $display("FAIL after_abort: result=%h at %0d required a at 34", res, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_multu_latency();
    test_signed();
    test_edges();
    test_ignore_start();
    test_cancel();
    test_back_to_back();
    test_rst_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
